ps2_key_display: RTL and testbench



---
 rtl/ps2_key_display_pkg.sv | 18 +
 rtl/ps2_key_display_hex_seg7.sv | 12 +
 rtl/ps2_key_display.sv | 107 ++++++++++
 tb/tb_ps2_key_display.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_display_pkg.sv
// Shared constants for the PS/2 key display: scan prefixes and the
// active-low hex seven-segment table.
package ps2_key_display_pkg;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;

  // Index 0 is the rightmost entry; segments are {g,f,e,d,c,b,a}.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/ps2_key_display_hex_seg7.sv
// One hex digit to active-low seven segments, blanked when disabled.
module hex_seg7
  import ps2_key_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       en,
  output logic [6:0] seg
);

  assign seg = en ? SEG_TABLE[value] : SEG_OFF;

endmodule

// File: rtl/ps2_key_display.sv
// PS/2 device-to-host receiver with make/break tracking and a
// two-digit hex seven-segment readout of the held key.
module ps2_key_display
  import ps2_key_display_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       key_down,
  output logic       frame_err,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [10:0]   frame;
  logic          last;
  logic          frame_ok;
  logic [7:0]    rx_byte;
  logic          brk;
  logic [TW-1:0] idle_cnt;

  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign frame    = {dat_sync[1], shreg};
  assign last     = fall && (bit_cnt == 4'd10);
  assign rx_byte  = frame[8:1];
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // A completing frame takes priority over the idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
    end else if (fall) begin
      idle_cnt <= '0;
      shreg    <= {dat_sync[1], shreg[9:1]};
      bit_cnt  <= last ? 4'd0 : bit_cnt + 4'd1;
    end else if (bit_cnt == 4'd0) begin
      idle_cnt <= '0;
    end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code      <= '0;
      key_down  <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (last) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
        end else if (rx_byte == BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == EXT) begin
          brk <= brk;
        end else if (brk) begin
          if (rx_byte == code) key_down <= 1'b0;
          brk <= 1'b0;
        end else begin
          code     <= rx_byte;
          key_down <= 1'b1;
        end
      end
    end
  end

  hex_seg7 u_seg_lo (
    .value (code[3:0]),
    .en    (key_down),
    .seg   (seg_lo)
  );

  hex_seg7 u_seg_hi (
    .value (code[7:4]),
    .en    (key_down),
    .seg   (seg_hi)
  );

endmodule

// File: tb/tb_ps2_key_display.sv
// Scoreboard bench for ps2_key_display: frames are driven bit by bit,
// expected readouts are queued at drive time and popped after each frame.
module tb_ps2_key_display;

  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       key_down;
  logic       frame_err;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;

  ps2_key_display #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .key_down  (key_down),
    .frame_err (frame_err),
    .seg_lo    (seg_lo),
    .seg_hi    (seg_hi)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int err_pulses = 0;
  int err_wide   = 0;
  logic err_prev = 1'b0;

  always @(posedge clk) begin
    if (frame_err) begin
      err_pulses++;
      if (err_prev) err_wide++;
    end
    err_prev = frame_err;
  end

  logic [7:0] m_code = 8'h00;
  logic       m_kd   = 1'b0;
  logic       m_brk  = 1'b0;
  logic [22:0] sb[$];

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79;
      4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12;
      4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10;
      4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21;
      4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [22:0] model_out();
    logic [6:0] hi, lo;
    hi = m_kd ? seg_ref(m_code[7:4]) : 7'h7F;
    lo = m_kd ? seg_ref(m_code[3:0]) : 7'h7F;
    return {m_code, m_kd, hi, lo};
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_brk = m_brk;
    else if (m_brk) begin
      if (b == m_code) m_kd = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_code = b;
      m_kd   = 1'b1;
    end
  endtask

  task automatic drive_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] f;
    logic par;
    par = ~(^b) ^ bad;
    f = {1'b1, par, b, 1'b0};
    if (!bad) model_byte(b);
    sb.push_back(model_out());
    drive_bits(f, 11);
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {code, key_down, seg_hi, seg_lo};
    total++;
    if (obs !== {8'h00, 1'b0, 7'h7F, 7'h7F})
      $display("FAIL reset_held: got %h want %h", obs, {8'h00, 1'b0, 7'h7F, 7'h7F});
    else passed++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    obs = {code, key_down, seg_hi, seg_lo, frame_err};
    total++;
    if (obs !== {8'h00, 1'b0, 7'h7F, 7'h7F, 1'b0})
      $display("FAIL reset_release: got %h", obs);
    else passed++;
  endtask

  task automatic test_make();
    logic [22:0] e;
    int err0;
    err0 = err_pulses;
    send_frame(8'h16, 1'b0);
    e = sb.pop_front();
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== e)
      $display("FAIL make_16: got %h want %h", {code, key_down, seg_hi, seg_lo}, e);
    else passed++;
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== {8'h16, 1'b1, 7'h79, 7'h02})
      $display("FAIL make_16_const: got %h", {code, key_down, seg_hi, seg_lo});
    else passed++;
    total++;
    if (err_pulses !== err0)
      $display("FAIL make_err: got %0d want %0d", err_pulses, err0);
    else passed++;
  endtask

  task automatic test_typematic_break();
    logic [7:0] seq [4] = '{8'h16, 8'h16, 8'hF0, 8'h16};
    logic [22:0] e;
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b0);
      e = sb.pop_front();
      total++;
      if ({code, key_down, seg_hi, seg_lo} !== e)
        $display("FAIL typematic_%0d: got %h want %h", i, {code, key_down, seg_hi, seg_lo}, e);
      else passed++;
    end
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== {8'h16, 1'b0, 7'h7F, 7'h7F})
      $display("FAIL break_blank: got %h", {code, key_down, seg_hi, seg_lo});
    else passed++;
  endtask

  task automatic test_other_break();
    logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h16};
    logic [22:0] e;
    for (int i = 0; i < 3; i++) begin
      send_frame(seq[i], 1'b0);
      e = sb.pop_front();
      total++;
      if ({code, key_down, seg_hi, seg_lo} !== e)
        $display("FAIL other_break_%0d: got %h want %h", i, {code, key_down, seg_hi, seg_lo}, e);
      else passed++;
    end
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== {8'h1C, 1'b1, 7'h79, 7'h46})
      $display("FAIL other_break_final: got %h", {code, key_down, seg_hi, seg_lo});
    else passed++;
  endtask

  task automatic test_parity_err();
    logic [22:0] e;
    int err0, wide0;
    err0 = err_pulses;
    wide0 = err_wide;
    send_frame(8'h1C, 1'b1);
    e = sb.pop_front();
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== e)
      $display("FAIL parity_hold: got %h want %h", {code, key_down, seg_hi, seg_lo}, e);
    else passed++;
    total++;
    if (err_pulses !== err0 + 1)
      $display("FAIL parity_pulse: got %0d want %0d", err_pulses, err0 + 1);
    else passed++;
    total++;
    if (err_wide !== wide0)
      $display("FAIL parity_width: got %0d want %0d", err_wide, wide0);
    else passed++;
  endtask

  task automatic test_timeout();
    logic [22:0] e;
    int err0;
    logic [10:0] junk;
    err0 = err_pulses;
    junk = 11'b000_0000_0110;
    drive_bits(junk, 4);
    repeat (TO + 10) @(posedge clk);
    send_frame(8'h45, 1'b0);
    e = sb.pop_front();
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== e)
      $display("FAIL timeout_45: got %h want %h", {code, key_down, seg_hi, seg_lo}, e);
    else passed++;
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== {8'h45, 1'b1, 7'h19, 7'h12})
      $display("FAIL timeout_45_const: got %h", {code, key_down, seg_hi, seg_lo});
    else passed++;
    total++;
    if (err_pulses !== err0)
      $display("FAIL timeout_err: got %0d want %0d", err_pulses, err0);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [22:0] e;
    int err0;
    logic [10:0] f;
    f = {1'b1, 1'b1, 8'h16, 1'b0};
    drive_bits(f, 6);
    #3 rst = 1'b1;
    m_code = 8'h00;
    m_kd   = 1'b0;
    m_brk  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== model_out())
      $display("FAIL midreset_clear: got %h want %h", {code, key_down, seg_hi, seg_lo}, model_out());
    else passed++;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    err0 = err_pulses;
    send_frame(8'h45, 1'b0);
    e = sb.pop_front();
    total++;
    if ({code, key_down, seg_hi, seg_lo} !== e)
      $display("FAIL midreset_45: got %h want %h", {code, key_down, seg_hi, seg_lo}, e);
    else passed++;
    total++;
    if (err_pulses !== err0)
      $display("FAIL midreset_err: got %0d want %0d", err_pulses, err0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_make();
    test_typematic_break();
    test_other_break();
    test_parity_err();
    test_timeout();
    test_reset_midframe();
    total++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
